// File: rtl/smd_pad_reader_pkg.sv
// Shared constants for the Mega Drive six-button pad poller.
package smd_pad_pkg;

    // Bit positions within the published buttons word.
    localparam int BTN_UP = 0;
    localparam int BTN_DW = 1;
    localparam int BTN_LF = 2;
    localparam int BTN_RG = 3;
    localparam int BTN_A  = 4;
    localparam int BTN_B  = 5;
    localparam int BTN_C  = 6;
    localparam int BTN_ST = 7;
    localparam int BTN_Z  = 8;
    localparam int BTN_Y  = 9;
    localparam int BTN_X  = 10;
    localparam int BTN_MD = 11;

    // Connector pin positions within the 6-bit pad data bus.
    localparam int PIN1 = 5;
    localparam int PIN2 = 4;
    localparam int PIN3 = 3;
    localparam int PIN4 = 2;
    localparam int PIN6 = 1;
    localparam int PIN9 = 0;

    // Number of TH phases in one read sequence.
    localparam int unsigned NUM_PHASES = 8;

    // Poller state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POLL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/smd_pad_reader_if.sv
// Host-side handshake and result bus of the pad poller.
interface smd_pad_if;

    logic        start;
    logic [11:0] buttons;
    logic        present;
    logic        six_btn;
    logic        valid;
    logic        busy;

    // Host logic requesting polls and consuming results.
    modport master (
        output start,
        input  buttons,
        input  present,
        input  six_btn,
        input  valid,
        input  busy
    );

    // The poller itself.
    modport slave (
        input  start,
        output buttons,
        output present,
        output six_btn,
        output valid,
        output busy
    );

endinterface

// File: rtl/smd_pad_reader_sync.sv
// Two-flop synchronizer for the asynchronous pad data pins.
module smd_pad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] d,
    output logic [5:0] q
);

    logic [5:0] meta;

    // Pins idle high (active-low, pulled up), so reset to all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/smd_pad_reader.sv
// Console-side poller for the Mega Drive six-button pad: drives TH through
// eight phases, samples the pad pins once per phase and publishes a decoded
// button word together with pad-presence and pad-type flags.
module smd_pad_reader
    import smd_pad_pkg::*;
#(
    parameter int unsigned HALF_CYCLES   = 130,
    parameter int unsigned POLL_INTERVAL = 167000
) (
    input  logic       clk,
    input  logic       rst,
    smd_pad_if.slave   host,
    input  logic [5:0] p,
    output logic       p7
);

    localparam int unsigned HC_W = $clog2(HALF_CYCLES);
    localparam int unsigned IC_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_CYCLES - 1);
    localparam logic [IC_W-1:0] IC_LAST = IC_W'((POLL_INTERVAL == 0) ? 0 : POLL_INTERVAL - 1);
    localparam logic [2:0]      PH_LAST = 3'(NUM_PHASES - 1);

    logic [1:0]      state;
    logic [HC_W-1:0] hc_cnt;
    logic [2:0]      phase;
    logic [IC_W-1:0] idle_cnt;
    logic [5:0]      p_s;

    // Only the sample bits the decoder looks at are kept.
    logic [5:0] s0;
    logic [3:0] s1;
    logic [3:0] s5;
    logic [3:0] s6;
    logic [3:0] s7;

    logic        auto_poll;
    logic        phase_end;
    logic        present_d;
    logic        six_d;
    logic [11:0] btn_d;

    smd_pad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (p),
        .q   (p_s)
    );

    assign auto_poll = (POLL_INTERVAL != 0) && (idle_cnt == IC_LAST);
    assign phase_end = (hc_cnt == HC_LAST);
    assign host.busy = (state != ST_IDLE);

    // Sequencer: idle timing, phase stepping and the TH select line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idle_cnt <= '0;
            hc_cnt   <= '0;
            phase    <= '0;
            p7       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    p7 <= 1'b1;
                    if (host.start || auto_poll) begin
                        state    <= ST_POLL;
                        idle_cnt <= '0;
                        hc_cnt   <= '0;
                        phase    <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_POLL: begin
                    if (phase_end) begin
                        hc_cnt <= '0;
                        if (phase == PH_LAST) begin
                            state <= ST_DONE;
                            p7    <= 1'b1;
                        end else begin
                            phase <= phase + 3'd1;
                            // Next phase is odd (TH low) exactly when this one is even.
                            p7    <= phase[0];
                        end
                    end else begin
                        hc_cnt <= hc_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    p7    <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    p7    <= 1'b1;
                end
            endcase
        end
    end

    // Capture the synchronized pins on the last cycle of the phases that matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= '1;
            s1 <= '1;
            s5 <= '1;
            s6 <= '1;
            s7 <= '1;
        end else if (state == ST_POLL && phase_end) begin
            case (phase)
                3'd0: s0 <= p_s;
                3'd1: s1 <= {p_s[PIN3], p_s[PIN4], p_s[PIN6], p_s[PIN9]};
                3'd5: s5 <= {p_s[PIN1], p_s[PIN2], p_s[PIN3], p_s[PIN4]};
                3'd6: s6 <= {p_s[PIN1], p_s[PIN2], p_s[PIN3], p_s[PIN4]};
                3'd7: s7 <= {p_s[PIN1], p_s[PIN2], p_s[PIN3], p_s[PIN4]};
                default: ;
            endcase
        end
    end

    // Decode the captured samples into active-high buttons and pad flags.
    always_comb begin
        present_d = (s1[3:2] == 2'b00);
        six_d     = present_d && (s5 == 4'b0000) && (s7 == 4'b1111);
        btn_d     = '0;
        if (present_d) begin
            btn_d[BTN_UP] = ~s0[PIN1];
            btn_d[BTN_DW] = ~s0[PIN2];
            btn_d[BTN_LF] = ~s0[PIN3];
            btn_d[BTN_RG] = ~s0[PIN4];
            btn_d[BTN_B]  = ~s0[PIN6];
            btn_d[BTN_C]  = ~s0[PIN9];
            btn_d[BTN_A]  = ~s1[1];
            btn_d[BTN_ST] = ~s1[0];
            if (six_d) begin
                btn_d[BTN_Z]  = ~s6[3];
                btn_d[BTN_Y]  = ~s6[2];
                btn_d[BTN_X]  = ~s6[1];
                btn_d[BTN_MD] = ~s6[0];
            end
        end
    end

    // Publish results atomically in the single DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            host.buttons <= '0;
            host.present <= 1'b0;
            host.six_btn <= 1'b0;
            host.valid   <= 1'b0;
        end else begin
            host.valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                host.buttons <= btn_d;
                host.present <= present_d;
                host.six_btn <= six_d;
            end
        end
    end

endmodule

// File: tb/tb_smd_pad_reader.sv
// Bench for smd_pad_reader: two pollers (manual and auto-interval) each wired
// to a behavioural six/three-button pad, checked every cycle against a
// time-since-start model plus hand-computed expectations.
module tb_smd_pad_reader;
    import smd_pad_pkg::*;

    localparam int H   = 130;
    localparam int PI1 = 2000;
    localparam int LAT = 8 * H + 1;

    localparam int PAD_NONE = 0;
    localparam int PAD_3    = 1;
    localparam int PAD_6    = 2;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic [5:0] p0, p1;
    logic       p7_0, p7_1;

    always #5 clk = ~clk;

    smd_pad_if hif0 ();
    smd_pad_if hif1 ();

    smd_pad_reader #(.HALF_CYCLES(H), .POLL_INTERVAL(0)) dut0 (
        .clk  (clk),
        .rst  (rst0),
        .host (hif0),
        .p    (p0),
        .p7   (p7_0)
    );

    smd_pad_reader #(.HALF_CYCLES(H), .POLL_INTERVAL(PI1)) dut1 (
        .clk  (clk),
        .rst  (rst1),
        .host (hif1),
        .p    (p1),
        .p7   (p7_1)
    );

    // ---------------- pad models ----------------
    int          ptype   [2] = '{PAD_6, PAD_6};
    logic [11:0] pressed [2] = '{12'h000, 12'h404};
    int          falls   [2] = '{0, 0};
    int          th_hi   [2] = '{0, 0};
    logic        th_prev [2] = '{1'b1, 1'b1};
    logic        th_now  [2];

    initial begin
        p0 = 6'h3F;
        p1 = 6'h3F;
    end

    // Pad output as a function of TH level and number of TH falls since pad reset.
    function automatic logic [5:0] pad_pins(input int pt, input logic [11:0] pr,
                                            input logic th, input int f);
        logic [11:0] n;
        n = ~pr;
        if (pt == PAD_NONE) return 6'h3F;
        if (th === 1'b1) begin
            if (pt == PAD_6 && f == 3)
                return {n[BTN_Z], n[BTN_Y], n[BTN_X], n[BTN_MD], 2'b11};
            return {n[BTN_UP], n[BTN_DW], n[BTN_LF], n[BTN_RG], n[BTN_B], n[BTN_C]};
        end
        if (pt == PAD_6 && f == 3) return {4'b0000, n[BTN_A], n[BTN_ST]};
        if (pt == PAD_6 && f >= 4) return {4'b1111, n[BTN_A], n[BTN_ST]};
        return {n[BTN_UP], n[BTN_DW], 2'b00, n[BTN_A], n[BTN_ST]};
    endfunction

    always @(negedge clk) begin
        th_now[0] = p7_0;
        th_now[1] = p7_1;
        for (int i = 0; i < 2; i++) begin
            if (th_prev[i] === 1'b1 && th_now[i] === 1'b0) falls[i]++;
            if (th_now[i] === 1'b1) begin
                th_hi[i]++;
                if (th_hi[i] >= 500) falls[i] = 0;
            end else begin
                th_hi[i] = 0;
            end
            th_prev[i] = th_now[i];
        end
        p0 = pad_pins(ptype[0], pressed[0], p7_0, falls[0]);
        p1 = pad_pins(ptype[1], pressed[1], p7_1, falls[1]);
    end

    // ---------------- reference model ----------------
    logic        m_active [2] = '{1'b0, 1'b0};
    int          m_t      [2] = '{0, 0};
    int          m_idle   [2] = '{0, 0};
    logic        m_valid  [2] = '{1'b0, 1'b0};
    logic [11:0] m_btn    [2] = '{12'h000, 12'h000};
    logic        m_pres   [2] = '{1'b0, 1'b0};
    logic        m_six    [2] = '{1'b0, 1'b0};
    int          m_pi     [2] = '{0, PI1};
    logic        m_rst    [2];
    logic        m_start  [2];

    always @(posedge clk) begin
        m_rst[0]   = rst0;
        m_rst[1]   = rst1;
        m_start[0] = hif0.start;
        m_start[1] = hif1.start;
        for (int i = 0; i < 2; i++) begin
            if (m_rst[i] === 1'b1) begin
                m_active[i] = 1'b0;
                m_idle[i]   = 0;
                m_valid[i]  = 1'b0;
                m_btn[i]    = '0;
                m_pres[i]   = 1'b0;
                m_six[i]    = 1'b0;
            end else begin
                m_valid[i] = 1'b0;
                if (!m_active[i]) begin
                    if (m_start[i] === 1'b1 || (m_pi[i] != 0 && m_idle[i] == m_pi[i] - 1)) begin
                        m_active[i] = 1'b1;
                        m_t[i]      = 0;
                        m_idle[i]   = 0;
                    end else begin
                        m_idle[i]++;
                    end
                end else begin
                    m_t[i]++;
                    if (m_t[i] == LAT) begin
                        m_active[i] = 1'b0;
                        m_valid[i]  = 1'b1;
                        m_pres[i]   = (ptype[i] != PAD_NONE);
                        m_six[i]    = (ptype[i] == PAD_6);
                        if (ptype[i] == PAD_NONE)   m_btn[i] = '0;
                        else if (ptype[i] == PAD_3) m_btn[i] = pressed[i] & 12'h0FF;
                        else                        m_btn[i] = pressed[i];
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    int   n_chk  = 0;
    int   n_pass = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, i, got, exp, $time);
    endtask

    task automatic cmp(input int i);
        logic        g_p7, g_busy, g_valid, g_pres, g_six;
        logic [11:0] g_btn;
        logic        e_p7;
        if (i == 0) begin
            g_p7 = p7_0; g_busy = hif0.busy; g_valid = hif0.valid;
            g_pres = hif0.present; g_six = hif0.six_btn; g_btn = hif0.buttons;
        end else begin
            g_p7 = p7_1; g_busy = hif1.busy; g_valid = hif1.valid;
            g_pres = hif1.present; g_six = hif1.six_btn; g_btn = hif1.buttons;
        end
        if (!m_active[i] || m_t[i] >= 8 * H) e_p7 = 1'b1;
        else                                 e_p7 = ((m_t[i] / H) % 2) == 0;
        chk("p7", i, 32'(g_p7), 32'(e_p7));
        chk("valid", i, 32'(g_valid), 32'(m_valid[i]));
        if (!m_active[i])        chk("busy", i, 32'(g_busy), 32'd0);
        else if (m_t[i] < 8 * H) chk("busy", i, 32'(g_busy), 32'd1);
        chk("outputs", i, 32'({g_btn, g_pres, g_six}), 32'({m_btn[i], m_pres[i], m_six[i]}));
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            cmp(0);
            cmp(1);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Start a manual poll on dut0; return cycles to valid and TH level at each phase start.
    task automatic run_poll0(output int n, output logic [7:0] seq);
        hif0.start = 1'b1;
        tick();
        hif0.start = 1'b0;
        n   = 0;
        seq = '0;
        while (hif0.valid !== 1'b1 && n < 3000) begin
            if (n % H == 0 && n < 8 * H) seq[n / H] = p7_0;
            tick();
            n++;
        end
    endtask

    task automatic wait_valid1(input string name, input int bound, output int n);
        n = 0;
        while (hif1.valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk(name, 1, 32'(n), 32'(bound - 1));
    endtask

    int         lat;
    int         vcount;
    int         gap;
    logic [7:0] seq;

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        hif0.start = 1'b0;
        hif1.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        tick();
        chk("rst_state", 0, 32'({p7_0, hif0.valid, hif0.busy, hif0.present, hif0.six_btn, hif0.buttons}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}));
        chk("rst_state", 1, 32'({p7_1, hif1.valid, hif1.busy, hif1.present, hif1.six_btn, hif1.buttons}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}));
        rst0 = 1'b0;
        rst1 = 1'b0;
        idle(600);

        // Six-button pad, nothing pressed.
        run_poll0(lat, seq);
        chk("t1_latency", 0, 32'(lat), 32'd1041);
        chk("t1_p7_seq", 0, 32'(seq), 32'h55);
        chk("t1_buttons", 0, 32'(hif0.buttons), 32'h000);
        chk("t1_flags", 0, 32'({hif0.present, hif0.six_btn}), 32'b11);
        idle(600);

        // A and Z pressed.
        pressed[0] = 12'h110;
        idle(10);
        run_poll0(lat, seq);
        chk("t2_buttons", 0, 32'(hif0.buttons), 32'h110);
        chk("t2_flags", 0, 32'({hif0.present, hif0.six_btn}), 32'b11);
        idle(600);

        // Three-button pad, up and start pressed.
        ptype[0]   = PAD_3;
        pressed[0] = 12'h081;
        idle(10);
        run_poll0(lat, seq);
        chk("t3_buttons", 0, 32'(hif0.buttons), 32'h081);
        chk("t3_flags", 0, 32'({hif0.present, hif0.six_btn}), 32'b10);
        idle(600);

        // Reset during phase 4 aborts the poll.
        ptype[0]   = PAD_6;
        pressed[0] = 12'h8A5;
        idle(10);
        hif0.start = 1'b1;
        tick();
        hif0.start = 1'b0;
        idle(4 * H + 5);
        chk("rst_mid_busy_before", 0, 32'(hif0.busy), 32'd1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        chk("rst_mid_p7", 0, 32'(p7_0), 32'd1);
        chk("rst_mid_busy", 0, 32'(hif0.busy), 32'd0);
        chk("rst_mid_outputs", 0, 32'({hif0.buttons, hif0.present, hif0.six_btn}), 32'd0);
        vcount = 0;
        for (int k = 0; k < 1500; k++) begin
            tick();
            if (hif0.valid === 1'b1) vcount++;
        end
        chk("rst_mid_no_valid", 0, 32'(vcount), 32'd0);

        // A fresh poll after the aborted one completes normally.
        run_poll0(lat, seq);
        chk("t5_latency", 0, 32'(lat), 32'd1041);
        chk("t5_buttons", 0, 32'(hif0.buttons), 32'h8A5);
        chk("t5_flags", 0, 32'({hif0.present, hif0.six_btn}), 32'b11);
        idle(600);

        // No pad: all pins float high.
        ptype[0]   = PAD_NONE;
        pressed[0] = 12'hFFF;
        idle(10);
        run_poll0(lat, seq);
        chk("t4_buttons", 0, 32'(hif0.buttons), 32'h000);
        chk("t4_flags", 0, 32'({hif0.present, hif0.six_btn}), 32'b00);

        // Auto-interval poller: period and ignored start while busy.
        wait_valid1("wait_valid1_a", 8000, gap);
        tick();
        wait_valid1("wait_valid1_b", 8000, gap);
        chk("auto_period", 1, 32'(gap + 1), 32'(PI1 + LAT));
        chk("auto_buttons", 1, 32'(hif1.buttons), 32'h404);
        chk("auto_flags", 1, 32'({hif1.present, hif1.six_btn}), 32'b11);
        gap = 0;
        while (hif1.busy !== 1'b1 && gap < 4000) begin
            tick();
            gap++;
        end
        idle(20);
        hif1.start = 1'b1;
        tick();
        hif1.start = 1'b0;
        wait_valid1("wait_valid1_c", 2000, gap);
        tick();
        wait_valid1("wait_valid1_d", 8000, gap);
        chk("auto_period_after_start", 1, 32'(gap + 1), 32'(PI1 + LAT));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
